// File: rtl/ds_dac_pkg.sv
// Shared types for the delta-sigma DAC sequencer: FSM encodings, sample type, ramp helper.
// Pure declarations and one combinational function; no latency.
// No flow control here.
package ds_dac_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 2'd0;
    localparam seq_state_t ST_RAMP_UP   = 2'd1;
    localparam seq_state_t ST_RUN       = 2'd2;
    localparam seq_state_t ST_RAMP_DOWN = 2'd3;

    typedef logic signed [7:0] sample_t;

    // One ramp step from cur toward tgt, clamped so it never passes tgt.
    // 9-bit intermediates keep cur +/- 64 from wrapping before the clamp.
    function automatic sample_t ramp_toward(input sample_t cur, input sample_t tgt,
                                            input logic [6:0] step);
        logic signed [8:0] c9;
        logic signed [8:0] t9;
        logic signed [8:0] s9;
        logic signed [8:0] n9;
        c9 = {cur[7], cur};
        t9 = {tgt[7], tgt};
        s9 = {2'b00, step};
        if (c9 < t9) begin
            n9 = c9 + s9;
            if (n9 > t9) n9 = t9;
        end else if (c9 > t9) begin
            n9 = c9 - s9;
            if (n9 < t9) n9 = t9;
        end else begin
            n9 = t9;
        end
        return n9[7:0];
    endfunction

endpackage

// File: rtl/ds_seq_fifo.sv
// Sample FIFO for the DAC sequencer with synchronous flush.
// Write visible at head one cycle after push; pop advances head on the clock edge.
// Push ignored while full (registered), pop ignored while empty; flush beats push.
module ds_seq_fifo
    import ds_dac_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       push,
    input  sample_t                    push_data,
    input  logic                       pop,
    input  logic                       flush,
    output sample_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sample_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ds_dac_sequencer.sv
// Sample sequencer for a delta-sigma DAC with soft ramp up/down; DS_SEQ_UNDERRUN_CNT_EN adds underrun_cnt.
// dac_value/underrun registered, updated on the edge where the period tick occurs.
// s_ready drops only when the FIFO is full; starved ticks hold the output and pulse underrun.
module ds_dac_sequencer
    import ds_dac_pkg::*;
#(
    parameter int OSR_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int RAMP_STEP  = 1
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                enable,
    input  logic [OSR_W-1:0]    osr,
    input  logic                s_valid,
    input  logic signed [7:0]   s_data,
    output logic                s_ready,
    output logic signed [7:0]   dac_value,
    output logic [1:0]          state,
    output logic                underrun
`ifdef DS_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);

    localparam int         CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [6:0] STEP = 7'(RAMP_STEP);

    logic [OSR_W-1:0] per_cnt;
    logic [OSR_W-1:0] osr_q;
    logic [OSR_W-1:0] osr_cur;
    logic             osr_loaded;
    logic             tick;

    seq_state_t       state_nxt;
    sample_t          dac_nxt;
    sample_t          ramp_up_v;
    sample_t          ramp_dn_v;
    logic             und_nxt;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    sample_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    // First period after reset uses the live osr so the latch takes effect immediately.
    assign osr_cur = osr_loaded ? osr_q : osr;
    assign tick    = (per_cnt == osr_cur);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            per_cnt    <= '0;
            osr_q      <= '0;
            osr_loaded <= 1'b0;
        end else begin
            osr_loaded <= 1'b1;
            if (!osr_loaded || tick) osr_q <= osr;
            per_cnt <= tick ? '0 : per_cnt + 1'b1;
        end
    end

    assign s_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign fifo_push = s_valid && !fifo_full;

    ds_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ramp_up_v = ramp_toward(dac_value, fifo_head, STEP);
    assign ramp_dn_v = ramp_toward(dac_value, 8'sd0, STEP);

    // Dropping enable wins over a coincident tick in RAMP_UP/RUN.
    always_comb begin
        state_nxt  = state;
        dac_nxt    = dac_value;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        und_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                dac_nxt = '0;
                if (enable) state_nxt = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (!enable) begin
                    state_nxt = ST_RAMP_DOWN;
                end else if (tick) begin
                    if (fifo_empty) begin
                        und_nxt = 1'b1;
                    end else begin
                        dac_nxt = ramp_up_v;
                        if (ramp_up_v == fifo_head) begin
                            fifo_pop  = 1'b1;
                            state_nxt = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt = ST_RAMP_DOWN;
                end else if (tick) begin
                    if (fifo_empty) begin
                        und_nxt = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                        dac_nxt  = fifo_head;
                    end
                end
            end
            default: begin
                if (tick) begin
                    dac_nxt = ramp_dn_v;
                    if (ramp_dn_v == 8'sd0) begin
                        state_nxt  = ST_IDLE;
                        fifo_flush = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            dac_value <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dac_value <= dac_nxt;
            underrun  <= und_nxt;
        end
    end

`ifdef DS_SEQ_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            underrun_cnt <= '0;
        end else if (state == ST_IDLE && state_nxt == ST_RAMP_UP) begin
            underrun_cnt <= '0;
        end else if (und_nxt && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ds_dac_sequencer.sv
// Directed bench: instance A (RAMP_STEP=1) and instance B (RAMP_STEP=4) share clk/clrn.
module tb_ds_dac_sequencer;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    logic              a_en, a_vld, a_rdy, a_und;
    logic signed [7:0] a_dat, a_dac;
    logic [7:0]        a_osr;
    logic [1:0]        a_st;
    logic              b_en, b_vld, b_rdy, b_und;
    logic signed [7:0] b_dat, b_dac;
    logic [7:0]        b_osr;
    logic [1:0]        b_st;
`ifdef DS_SEQ_UNDERRUN_CNT_EN
    logic [15:0]       a_ucnt, b_ucnt;
`endif

    ds_dac_sequencer #(.OSR_W(8), .FIFO_DEPTH(8), .RAMP_STEP(1)) u_a (
        .clk(clk), .clrn(clrn), .enable(a_en), .osr(a_osr),
        .s_valid(a_vld), .s_data(a_dat), .s_ready(a_rdy),
        .dac_value(a_dac), .state(a_st), .underrun(a_und)
`ifdef DS_SEQ_UNDERRUN_CNT_EN
        , .underrun_cnt(a_ucnt)
`endif
    );

    ds_dac_sequencer #(.OSR_W(8), .FIFO_DEPTH(8), .RAMP_STEP(4)) u_b (
        .clk(clk), .clrn(clrn), .enable(b_en), .osr(b_osr),
        .s_valid(b_vld), .s_data(b_dat), .s_ready(b_rdy),
        .dac_value(b_dac), .state(b_st), .underrun(b_und)
`ifdef DS_SEQ_UNDERRUN_CNT_EN
        , .underrun_cnt(b_ucnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              en;
        logic              vld;
        logic signed [7:0] dat;
        int                ncyc;
        int                dac;
        int                st;
        int                rdy;
        int                und;
    } vec_t;

    vec_t tbl [15];
    logic signed [7:0] bvals [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // osr=3 ramp to 5 with three queued 5s, drain to underrun, then one more sample and ramp down.
        tbl[0]  = '{1'b0, 1'b1, 8'sd5, 3,  0, 0, 1, 0};
        tbl[1]  = '{1'b1, 1'b0, 8'sd0, 1,  0, 1, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 8'sd0, 4,  1, 1, 1, 0};
        tbl[3]  = '{1'b1, 1'b0, 8'sd0, 4,  2, 1, 1, 0};
        tbl[4]  = '{1'b1, 1'b0, 8'sd0, 8,  4, 1, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 8'sd0, 4,  5, 2, 1, 0};
        tbl[6]  = '{1'b1, 1'b0, 8'sd0, 8,  5, 2, 1, 0};
        tbl[7]  = '{1'b1, 1'b0, 8'sd0, 4,  5, 2, 1, 1};
        tbl[8]  = '{1'b1, 1'b0, 8'sd0, 1,  5, 2, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 8'sd9, 1,  5, 2, 1, 0};
        tbl[10] = '{1'b1, 1'b0, 8'sd0, 2,  9, 2, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 8'sd0, 1,  9, 3, 1, 0};
        tbl[12] = '{1'b0, 1'b0, 8'sd0, 3,  8, 3, 1, 0};
        tbl[13] = '{1'b0, 1'b0, 8'sd0, 28, 1, 3, 1, 0};
        tbl[14] = '{1'b0, 1'b0, 8'sd0, 4,  0, 0, 1, 0};
        bvals   = '{-8'sd10, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7};

        clrn = 1'b0;
        a_en = 1'b0; a_vld = 1'b0; a_dat = '0; a_osr = 8'd3;
        b_en = 1'b0; b_vld = 1'b0; b_dat = '0; b_osr = 8'd0;
        repeat (3) cycle();
        chk("rst_a_dac", a_dac, 0);
        chk("rst_a_state", a_st, 0);
        chk("rst_a_ready", a_rdy, 1);
        chk("rst_a_underrun", a_und, 0);
        chk("rst_b_dac", b_dac, 0);
        chk("rst_b_ready", b_rdy, 1);
`ifdef DS_SEQ_UNDERRUN_CNT_EN
        chk("rst_a_ucnt", a_ucnt, 0);
`endif
        clrn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            a_en  = tbl[i].en;
            a_vld = tbl[i].vld;
            a_dat = tbl[i].dat;
            repeat (tbl[i].ncyc) cycle();
            chk($sformatf("vec%0d_dac", i), a_dac, tbl[i].dac);
            chk($sformatf("vec%0d_state", i), a_st, tbl[i].st);
            chk($sformatf("vec%0d_ready", i), a_rdy, tbl[i].rdy);
            chk($sformatf("vec%0d_underrun", i), a_und, tbl[i].und);
        end

        // osr=0: tick every cycle; ramp to 3, play 7, then starve.
        a_osr = 8'd0;
        repeat (8) cycle();
        a_en = 1'b1; a_vld = 1'b1; a_dat = 8'sd3;
        cycle();
        chk("osr0_rampup_state", a_st, 1);
`ifdef DS_SEQ_UNDERRUN_CNT_EN
        chk("ucnt_clear_on_start", a_ucnt, 0);
`endif
        a_dat = 8'sd7;
        cycle();
        chk("osr0_ramp1", a_dac, 1);
        a_vld = 1'b0;
        cycle();
        chk("osr0_ramp2", a_dac, 2);
        cycle();
        chk("osr0_ramp3_dac", a_dac, 3);
        chk("osr0_ramp3_run", a_st, 2);
        cycle();
        chk("osr0_play7", a_dac, 7);
        chk("osr0_play7_und", a_und, 0);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk($sformatf("starve%0d_und", k), a_und, 1);
            chk($sformatf("starve%0d_dac", k), a_dac, 7);
`ifdef DS_SEQ_UNDERRUN_CNT_EN
            chk($sformatf("starve%0d_ucnt", k), a_ucnt, k);
`endif
        end
        a_vld = 1'b1; a_dat = 8'sd20;
        cycle();
        chk("push_tick_empty_und", a_und, 1);
        chk("push_tick_empty_dac", a_dac, 7);
        a_vld = 1'b0;
        cycle();
        chk("push_then_pop_dac", a_dac, 20);
        chk("push_then_pop_und", a_und, 0);

        // B: fill to full, ramp down from -10 with step 4.
        for (int i = 0; i < 8; i++) begin
            b_vld = 1'b1; b_dat = bvals[i];
            cycle();
        end
        chk("full_ready", b_rdy, 0);
        b_dat = 8'sd99; b_en = 1'b1;
        cycle();
        chk("full_start_state", b_st, 1);
        chk("full_push_rejected", b_rdy, 0);
        cycle();
        chk("neg_ramp1", b_dac, -4);
        cycle();
        chk("neg_ramp2", b_dac, -8);
        chk("neg_ramp2_ready", b_rdy, 0);
        cycle();
        chk("neg_ramp3_dac", b_dac, -10);
        chk("neg_ramp3_run", b_st, 2);
        chk("pop_while_full_ready", b_rdy, 1);
        b_vld = 1'b0; b_en = 1'b0;
        cycle();
        chk("down_enter_state", b_st, 3);
        chk("down_enter_dac", b_dac, -10);
        cycle();
        chk("down1", b_dac, -6);
        cycle();
        chk("down2", b_dac, -2);
        cycle();
        chk("down3_dac", b_dac, 0);
        chk("down3_idle", b_st, 0);
        chk("down3_ready", b_rdy, 1);
        b_en = 1'b1;
        cycle();
        chk("restart_state", b_st, 1);
        cycle();
        chk("flushed_und", b_und, 1);
        chk("flushed_dac", b_dac, 0);
        b_vld = 1'b1; b_dat = 8'sd20;
        cycle();
        chk("push_empty_tick_und", b_und, 1);
        b_vld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk($sformatf("up_step%0d", k), b_dac, 4 * k);
        end
        chk("up_run", b_st, 2);
        b_en = 1'b0;
        cycle();
        chk("toggle_down_state", b_st, 3);
        b_en = 1'b1;
        repeat (4) cycle();
        chk("toggle_ignored_state", b_st, 3);
        chk("toggle_ignored_dac", b_dac, 4);
        cycle();
        chk("toggle_idle_state", b_st, 0);
        chk("toggle_idle_dac", b_dac, 0);
        cycle();
        chk("toggle_rampup_state", b_st, 1);

        // A: async reset mid-RUN with 77 playing and a sample queued.
        a_vld = 1'b1; a_dat = 8'sd77;
        cycle();
        a_dat = 8'sd55;
        cycle();
        chk("pre_reset_dac", a_dac, 77);
        chk("pre_reset_state", a_st, 2);
        a_vld = 1'b0;
        #3 clrn = 1'b0;
        #1;
        chk("async_rst_dac", a_dac, 0);
        chk("async_rst_state", a_st, 0);
        chk("async_rst_ready", a_rdy, 1);
        chk("async_rst_und", a_und, 0);
`ifdef DS_SEQ_UNDERRUN_CNT_EN
        chk("async_rst_ucnt", a_ucnt, 0);
`endif
        @(posedge clk);
        #1 clrn = 1'b1;
        cycle();
        chk("post_rst_state", a_st, 1);
        cycle();
        chk("post_rst_fifo_discarded_und", a_und, 1);
        chk("post_rst_fifo_discarded_dac", a_dac, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_dac_sequencer.md
DS_DAC_SEQUENCER -- requirements
Module: ds_dac_sequencer

Interface
REQ-001 SHALL have parameter OSR_W, default 8, width of the sample-period register.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO depth (power of 2, at least 2).
REQ-003 SHALL have parameter RAMP_STEP, default 1, dac_value change per tick during ramps (1..64).
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port clrn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  level; 1 = play, 0 = soft-mute and stop.
REQ-007 SHALL have port osr  in  OSR_W  sample period in clk cycles minus 1.
REQ-008 SHALL have ports s_valid  in  1, s_data  in  8 signed, s_ready  out  1: sample stream; transfer when s_valid and s_ready.
REQ-009 SHALL have port dac_value  out  8 signed  registered code driven to the delta-sigma DAC value input.
REQ-010 SHALL have port state  out  2  current FSM state encoding.
REQ-011 SHALL have port underrun  out  1  one-cycle pulse per starved tick.

Function
REQ-012 Period counter SHALL count 0..osr_latched; tick asserted for the one cycle where count equals osr_latched; count then wraps to 0.
REQ-013 osr SHALL be latched at reset release and at every tick; osr=0 gives a tick every cycle.
REQ-014 FSM states SHALL be IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.
REQ-015 IDLE: dac_value=0; enable=1 SHALL move to RAMP_UP next cycle.
REQ-016 RAMP_UP, on tick with FIFO non-empty: dac_value SHALL step by RAMP_STEP toward the FIFO head without popping, clamped to the head value (no overshoot); on equality it SHALL pop the head and go to RUN.
REQ-017 RAMP_UP, on tick with FIFO empty: dac_value SHALL hold and underrun SHALL pulse.
REQ-018 RUN, on tick: if FIFO non-empty, pop and load dac_value with the head in the same edge; else hold dac_value and pulse underrun.
REQ-019 enable=0 in RAMP_UP or RUN SHALL move to RAMP_DOWN next cycle.
REQ-020 RAMP_DOWN, on tick: dac_value SHALL step by RAMP_STEP toward 0, clamped at 0; at 0 go to IDLE and flush the FIFO in the same edge.
REQ-021 enable re-asserted during RAMP_DOWN SHALL be ignored until IDLE is reached.
REQ-022 s_ready SHALL equal not-full of the registered count; a push while full is not accepted even with a simultaneous pop.
REQ-023 Push and pop in the same cycle when not full SHALL leave the count unchanged; pop sees pre-push contents, so push+tick on an empty FIFO is an underrun.
REQ-024 Samples SHALL be accepted in every state; the flush on entry to IDLE takes priority over a same-cycle push.
REQ-025 Ramp arithmetic SHALL use 9-bit signed intermediates; results stay within -128..127.

Reset
REQ-026 While clrn=0: state=IDLE, dac_value=0, counter=0, FIFO empty, s_ready=1, underrun=0.
REQ-027 Reset mid-ramp or mid-RUN SHALL discard FIFO contents with no further ticks.

Configuration
REQ-028 With DS_SEQ_UNDERRUN_CNT_EN defined: output underrun_cnt 16 bits, saturating at 0xFFFF, +1 per underrun pulse, cleared by reset and on IDLE->RAMP_UP.
REQ-029 Without DS_SEQ_UNDERRUN_CNT_EN: the port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package ds_dac_pkg SHALL hold the FSM state typedef and encodings, and the 8-bit signed sample typedef.
REQ-031 FIFO SHALL be sub-module ds_seq_fifo (push/pop/flush, full/empty, count); FSM, period counter and ramp logic stay in the top level.

Verification
REQ-032 osr=3, RAMP_STEP=1, push 5,5,5, enable=1 -> dac_value 1,2,3,4,5 on ticks every 4 clk, then RUN, one pop per tick.
REQ-033 RUN, osr=0, FIFO drained -> underrun pulse every cycle, dac_value holds last sample; underrun_cnt increments per pulse when macro defined.
REQ-034 dac_value=-10, RAMP_STEP=4, enable=0 -> -6,-2,0 on successive ticks, then IDLE, FIFO count 0.
REQ-035 Fill FIFO to 8 -> s_ready=0; push with pop on the same cycle rejected; next cycle s_ready=1.
REQ-036 clrn low for one cycle mid-RUN with dac_value=77 -> dac_value=0, state=IDLE, s_ready=1 immediately (asynchronous).
REQ-037 enable toggled 0->1 during RAMP_DOWN -> ramp completes to 0, IDLE for exactly one cycle, then RAMP_UP.
